// File: rtl/alu_multiciclo.sv
// alu_multiciclo: registered, handshaked execution unit for the MIPS datapath.
// Logic/arith/shift ops complete in one cycle; MULTU/DIVU iterate one bit
// per cycle and return HI/LO. Results are held in DONE until out_ready.
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  input  logic [3:0]       controle,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rst,
  output logic [WIDTH-1:0] rst_hi,
  output logic             zero,
  output logic             div_zero
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  localparam logic [SHW:0] CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0] CNT_LOAD = (SHW+1)'(WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;

  logic [3:0]         op_r;      // operation being iterated
  logic [WIDTH-1:0]   opb_r;     // multiplicand / divisor
  logic [WIDTH-1:0]   acc_r;     // running HI: partial product upper half / remainder
  logic [WIDTH-1:0]   q_r;       // running LO: multiplier shifting out / quotient shifting in
  logic [SHW:0]       cnt_r;     // iterations still to perform

  logic               is_iter_s;
  logic [SHW-1:0]     sh_s;
  logic [WIDTH-1:0]   single_lo_s;
  logic [WIDTH-1:0]   single_hi_s;
  logic               single_dz_s;

  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     shl_s;
  logic [WIDTH-1:0]   diff_s;
  logic [WIDTH-1:0]   acc_nxt_s;
  logic [WIDTH-1:0]   q_nxt_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign sh_s      = r2[SHW-1:0];
  // A zero divisor short-circuits to the single-cycle path.
  assign is_iter_s = (controle == OP_MULTU) ||
                     ((controle == OP_DIVU) && (r2 != {WIDTH{1'b0}}));

  // Single-cycle result computed straight from the accepted operands.
  always_comb begin
    single_lo_s = {WIDTH{1'b0}};
    single_hi_s = {WIDTH{1'b0}};
    single_dz_s = 1'b0;
    case (controle)
      OP_AND: single_lo_s = r1 & r2;
      OP_OR:  single_lo_s = r1 | r2;
      OP_ADD: single_lo_s = r1 + r2;
      OP_SUB: single_lo_s = r1 - r2;
      OP_SLT: single_lo_s = {{(WIDTH-1){1'b0}}, (r1 < r2)};
      OP_NOR: single_lo_s = ~(r1 | r2);
      OP_SLL: single_lo_s = r1 << sh_s;
      OP_SRL: single_lo_s = r1 >> sh_s;
      OP_SRA: single_lo_s = $unsigned($signed(r1) >>> sh_s);
      OP_DIVU: begin
        single_lo_s = {WIDTH{1'b1}};
        single_hi_s = r1;
        single_dz_s = 1'b1;
      end
      default: begin
        single_lo_s = {WIDTH{1'b0}};
        single_hi_s = {WIDTH{1'b0}};
        single_dz_s = 1'b0;
      end
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    sum_s     = {1'b0, acc_r} + (q_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    shl_s     = {acc_r, q_r[WIDTH-1]};
    diff_s    = shl_s[WIDTH-1:0] - opb_r;
    acc_nxt_s = acc_r;
    q_nxt_s   = q_r;
    if (op_r == OP_MULTU) begin
      acc_nxt_s = sum_s[WIDTH:1];
      q_nxt_s   = {sum_s[0], q_r[WIDTH-1:1]};
    end else if (shl_s >= {1'b0, opb_r}) begin
      acc_nxt_s = diff_s;
      q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
    end else begin
      acc_nxt_s = shl_s[WIDTH-1:0];
      q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
    end
  end

  // Control FSM next state.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          if (is_iter_s) begin
            state_s = ST_BUSY;
          end else begin
            state_s = ST_DONE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r == CNT_ONE) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Control FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r      <= 4'b0000;
      opb_r     <= {WIDTH{1'b0}};
      acc_r     <= {WIDTH{1'b0}};
      q_r       <= {WIDTH{1'b0}};
      cnt_r     <= {(SHW+1){1'b0}};
      out_valid <= 1'b0;
      rst       <= {WIDTH{1'b0}};
      rst_hi    <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            op_r  <= controle;
            opb_r <= r2;
            zero  <= (r1 == r2);
            if (is_iter_s) begin
              acc_r <= {WIDTH{1'b0}};
              q_r   <= r1;
              cnt_r <= CNT_LOAD;
            end else begin
              rst       <= single_lo_s;
              rst_hi    <= single_hi_s;
              div_zero  <= single_dz_s;
              out_valid <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          acc_r <= acc_nxt_s;
          q_r   <= q_nxt_s;
          cnt_r <= cnt_r - CNT_ONE;
          if (cnt_r == CNT_ONE) begin
            rst       <= q_nxt_s;
            rst_hi    <= acc_nxt_s;
            div_zero  <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiciclo.sv
// Testbench for alu_multiciclo: directed corner cases plus randomized ops on a
// 32-bit and an 8-bit instance, checked against an arithmetic reference model.
module tb_alu_multiciclo;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_MULTU = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  logic clk = 1'b0;
  logic rst_n;
  logic iv, ordy, sel8;
  logic [31:0] a, b;
  logic [3:0] ctl;

  logic rdy32, ov32, z32, dz32;
  logic [31:0] res32, hi32;
  logic rdy8, ov8, z8, dz8;
  logic [7:0] res8, hi8;

  logic ready_m, ovalid_m, zero_m, dz_m;
  logic [31:0] res_m, hi_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_multiciclo #(.WIDTH(32), .SHW(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & ~sel8), .in_ready(rdy32),
    .r1(a), .r2(b), .controle(ctl), .out_valid(ov32), .out_ready(ordy & ~sel8),
    .rst(res32), .rst_hi(hi32), .zero(z32), .div_zero(dz32)
  );

  alu_multiciclo #(.WIDTH(8), .SHW(3)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv & sel8), .in_ready(rdy8),
    .r1(a[7:0]), .r2(b[7:0]), .controle(ctl), .out_valid(ov8), .out_ready(ordy & sel8),
    .rst(res8), .rst_hi(hi8), .zero(z8), .div_zero(dz8)
  );

  assign ready_m  = sel8 ? rdy8 : rdy32;
  assign ovalid_m = sel8 ? ov8  : ov32;
  assign zero_m   = sel8 ? z8   : z32;
  assign dz_m     = sel8 ? dz8  : dz32;
  assign res_m    = sel8 ? {24'd0, res8} : res32;
  assign hi_m     = sel8 ? {24'd0, hi8}  : hi32;

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: what the unit should return, from plain arithmetic.
  function automatic void model(input int w, input logic [3:0] op,
                                input longint unsigned x, input longint unsigned y,
                                output longint unsigned lo, output longint unsigned hi,
                                output bit dz);
    longint unsigned mask, p;
    int sh;
    mask = (64'd1 << w) - 64'd1;
    sh = int'(y % longint'(w));
    lo = 0; hi = 0; dz = 0;
    case (op)
      OP_AND:   lo = x & y;
      OP_OR:    lo = x | y;
      OP_ADD:   lo = (x + y) & mask;
      OP_SUB:   lo = (x - y) & mask;
      OP_SLT:   lo = (x < y) ? 1 : 0;
      OP_NOR:   lo = ~(x | y) & mask;
      OP_SLL:   lo = (x << sh) & mask;
      OP_SRL:   lo = x >> sh;
      OP_SRA:   lo = ((x >> (w - 1)) & 1) != 0 ? ((x >> sh) | (mask & ~(mask >> sh))) : (x >> sh);
      OP_MULTU: begin p = x * y; lo = p & mask; hi = (p >> w) & mask; end
      OP_DIVU:  begin
        if (y == 0) begin lo = mask; hi = x; dz = 1; end
        else begin lo = x / y; hi = x % y; end
      end
      default:  begin lo = 0; hi = 0; end
    endcase
  endfunction

  // One full transaction: accept, wait for result, optional backpressure, retire.
  task automatic do_op(input bit s8, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input int stall);
    int w, lat, n;
    longint unsigned mask, ma, mb, elo, ehi;
    bit edz, busy_rdy;
    logic [31:0] held;
    w = s8 ? 8 : 32;
    mask = (64'd1 << w) - 64'd1;
    ma = longint'(x) & mask;
    mb = longint'(y) & mask;
    model(w, op, ma, mb, elo, ehi, edz);
    lat = ((op == OP_MULTU) || (op == OP_DIVU && mb != 0)) ? w + 1 : 1;
    sel8 = s8;
    @(negedge clk);
    n = 0;
    while (!ready_m && n < 100) begin @(negedge clk); n++; end
    check("in_ready_idle", ready_m, 1);
    iv = 1'b1; a = x; b = y; ctl = op;
    @(negedge clk);
    iv = 1'b0; a = $urandom; b = $urandom; ctl = 4'($urandom);
    n = 1; busy_rdy = 1'b0;
    while (!ovalid_m && n < lat + 5) begin
      busy_rdy |= ready_m;
      @(negedge clk);
      n++;
    end
    check("latency", n, lat);
    check("in_ready_busy", busy_rdy, 0);
    check("rst", res_m, elo);
    check("rst_hi", hi_m, ehi);
    check("zero", zero_m, (ma == mb) ? 1 : 0);
    check("div_zero", dz_m, edz);
    check("in_ready_done", ready_m, 0);
    held = res_m;
    if (stall > 0) begin
      ordy = 1'b0;
      repeat (stall) @(negedge clk);
      check("stall_valid", ovalid_m, 1);
      check("stall_rst", res_m, held);
      check("stall_in_ready", ready_m, 0);
    end
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check("retire_valid", ovalid_m, 0);
    check("retire_in_ready", ready_m, 1);
  endtask

  logic [3:0] legal_ops [12] = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR,
                                 OP_SLL, OP_SRL, OP_SRA, OP_MULTU, OP_DIVU, OP_DIVU};

  task automatic random_ops(input bit s8, input int count);
    logic [3:0] op;
    logic [31:0] x, y;
    int k;
    for (int i = 0; i < count; i++) begin
      k = $urandom_range(0, 13);
      op = (k < 12) ? legal_ops[k] : 4'($urandom);
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 4))
        0: y = 32'd0;
        1: y = x;
        2: x = 32'hFFFF_FFFF;
        default: ;
      endcase
      do_op(s8, op, x, y, $urandom_range(0, 3));
    end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; iv = 1'b0; ordy = 1'b0; sel8 = 1'b0;
    a = 32'd0; b = 32'd0; ctl = 4'd0;
    repeat (3) @(negedge clk);
    check("reset_valid", ov32, 0);
    check("reset_rst", res32, 0);
    check("reset_hi", hi32, 0);
    check("reset_zero", z32, 0);
    check("reset_dz", dz32, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", rdy32, 1);

    do_op(1'b0, OP_ADD,   32'hFFFF_FFFF, 32'h0000_0001, 0);
    do_op(1'b0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(1'b0, OP_DIVU,  32'd100,       32'd7,         0);
    do_op(1'b0, OP_DIVU,  32'd5,         32'd0,         0);
    do_op(1'b0, OP_SRA,   32'h8000_0000, 32'h0000_0024, 0);
    do_op(1'b0, OP_SLT,   32'h0000_0001, 32'hFFFF_FFFF, 0);
    do_op(1'b0, OP_NOR,   32'd0,         32'd0,         0);
    do_op(1'b0, OP_SUB,   32'd5,         32'd5,         0);
    do_op(1'b0, OP_ADD,   32'd3,         32'd4,         10);

    // Reset in the middle of a MULTU.
    sel8 = 1'b0;
    iv = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ctl = OP_MULTU;
    @(negedge clk);
    iv = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid", ov32, 0);
    check("abort_rst", res32, 0);
    check("abort_hi", hi32, 0);
    check("abort_zero", z32, 0);
    check("abort_dz", dz32, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_in_ready", rdy32, 1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (ov32) seen++;
    end
    check("abort_no_stale", seen, 0);

    random_ops(1'b0, 40);
    do_op(1'b1, OP_MULTU, 32'hFF, 32'hFF, 0);
    do_op(1'b1, OP_DIVU,  32'd100, 32'd7, 2);
    do_op(1'b1, OP_DIVU,  32'd5,   32'd0, 0);
    do_op(1'b1, OP_SRA,   32'h80,  32'h0C, 0);
    random_ops(1'b1, 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
